// File: rtl/load_use_stall_ctrl_pkg.sv
// Shared constants for the ID-stage hazard logic: MIPS opcodes, instruction
// field positions, stall FSM encoding and the source-decode bundle.
package load_use_stall_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_BR_WAIT = 1'b1;

  typedef struct packed {
    logic       uses_rs;
    logic       uses_rt;
    logic       is_branch;
    logic       is_lw;
    logic [4:0] rs;
    logic [4:0] rt;
  } src_decode_t;

  // A producer only matters when it really writes a register other than $0.
  function automatic logic reg_hit(input logic       reg_write,
                                   input logic [4:0] dst,
                                   input logic       used,
                                   input logic [4:0] src);
    return reg_write && (dst != 5'd0) && used && (dst == src);
  endfunction

endpackage

// File: rtl/load_use_stall_ctrl_instr_src_decode.sv
// Source-operand decode of the ID instruction, shared with the address
// forward detector so both blocks agree on which registers are read.
module instr_src_decode
  import load_use_stall_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic        uses_rs,
  output logic        uses_rt,
  output logic        is_branch,
  output logic        is_lw,
  output logic [4:0]  rs,
  output logic [4:0]  rt
);

  logic [5:0]  opcode;
  logic        unused_imm;

  assign opcode     = instr[OPC_HI:OPC_LO];
  assign rs         = instr[RS_HI:RS_LO];
  assign rt         = instr[RT_HI:RT_LO];
  assign unused_imm = &{1'b0, instr[15:0]};

  always_comb begin
    uses_rs   = 1'b1;
    uses_rt   = 1'b0;
    is_branch = 1'b0;
    is_lw     = 1'b0;
    case (opcode)
      OP_J, OP_JAL, OP_LUI: uses_rs = 1'b0;
      default:              uses_rs = 1'b1;
    endcase
    case (opcode)
      OP_RTYPE, OP_SW:      uses_rt = 1'b1;
      OP_BEQ, OP_BNE: begin
        uses_rt   = 1'b1;
        is_branch = 1'b1;
      end
      OP_LW:                is_lw = 1'b1;
      default:              uses_rt = 1'b0;
    endcase
  end

endmodule

// File: rtl/load_use_stall_ctrl.sv
// ID-stage stall controller: freezes PC and IF/ID and bubbles ID/EX on
// load-use, branch-operand and lw base-address hazards; counts stall cycles.
module load_use_stall_ctrl
  import load_use_stall_ctrl_pkg::*;
#(
  parameter bit USE_ADDR_FWD = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      IF_ID_instr,
  input  logic [4:0]       ID_EX_dstReg,
  input  logic             ID_EX_RegWrite,
  input  logic             ID_EX_MemRead,
  input  logic             ram_addr_fwd,
  input  logic             flush,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_cycles
);

  src_decode_t dec;
  logic [0:0]  state;
  logic [0:0]  state_next;
  logic        match_rs;
  logic        match_rt;
  logic        match;
  logic        hazard_load;
  logic        hazard_br;
  logic        hazard_addr;
  logic        addr_uncovered;
  logic        stall;

  instr_src_decode u_decode (
    .instr     (IF_ID_instr),
    .uses_rs   (dec.uses_rs),
    .uses_rt   (dec.uses_rt),
    .is_branch (dec.is_branch),
    .is_lw     (dec.is_lw),
    .rs        (dec.rs),
    .rt        (dec.rt)
  );

  always_comb begin
    match_rs       = reg_hit(ID_EX_RegWrite, ID_EX_dstReg, dec.uses_rs, dec.rs);
    match_rt       = reg_hit(ID_EX_RegWrite, ID_EX_dstReg, dec.uses_rt, dec.rt);
    match          = match_rs || match_rt;
    addr_uncovered = !USE_ADDR_FWD || !ram_addr_fwd;
    hazard_load    = match && ID_EX_MemRead;
    hazard_br      = match && !ID_EX_MemRead && dec.is_branch;
    hazard_addr    = dec.is_lw && match_rs && !ID_EX_MemRead && addr_uncovered;
  end

  // A branch waiting on a load needs the loaded value past MEM, hence the
  // second, unconditional bubble in BR_WAIT.
  always_comb begin
    stall      = 1'b0;
    state_next = ST_RUN;
    if (!reset && !flush) begin
      case (state)
        ST_BR_WAIT: stall = 1'b1;
        default: begin
          stall = hazard_load || hazard_br || hazard_addr;
          if (hazard_load && dec.is_branch)
            state_next = ST_BR_WAIT;
        end
      endcase
    end
  end

  assign pc_write     = !stall;
  assign if_id_write  = !stall;
  assign id_ex_bubble = stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_RUN;
      stall_cycles <= '0;
    end else begin
      state <= state_next;
      if (id_ex_bubble && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
